// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared encodings and types for the MIPS fetch/decode stages
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [1:0] JUMP_NONE = 2'd0;
   localparam logic [1:0] JUMP_J    = 2'd1;
   localparam logic [1:0] JUMP_JR   = 2'd2;

   typedef enum logic [1:0] {
      FS_FETCH = 2'd0,
      FS_HOLD  = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_e;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : instruction-memory request/ready handshake
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;

   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);

endinterface : fetch_unit_if

`default_nettype wire

// File: rtl/pc_redirect_mux.sv
// ============================================================================
// pc_redirect_mux : redirect flag and target select from EX/MEM control
// Revision        : 1.0
// ============================================================================
`default_nettype none

module pc_redirect_mux
   import mips_pkg::*;
(
   input  wire logic        EM_PCSrc,
   input  wire logic [1:0]  EM_jump,
   input  wire logic [31:0] EM_branch_addr,
   input  wire logic [31:0] EM_jump_addr,
   input  wire logic [31:0] EM_jr_addr,
   output logic             redirect,
   output logic [31:0]      target
);

   always_comb begin
      redirect = EM_PCSrc | (EM_jump == JUMP_J) | (EM_jump == JUMP_JR);
      // Jumps override a simultaneously taken branch; jr wins over j.
      if (EM_jump == JUMP_JR) begin
         target = EM_jr_addr;
      end else if (EM_jump == JUMP_J) begin
         target = EM_jump_addr;
      end else begin
         target = EM_branch_addr;
      end
   end

endmodule : pc_redirect_mux

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC, single-outstanding instruction fetch and IF/ID register
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        stall,
   input  wire logic        EM_PCSrc,
   input  wire logic [1:0]  EM_jump,
   input  wire logic [31:0] EM_branch_addr,
   input  wire logic [31:0] EM_jump_addr,
   input  wire logic [31:0] EM_jr_addr,
   fetch_unit_if.master     imem,
   output logic [31:0]      IF_Instr,
   output logic [31:0]      IF_PC4,
   output logic             IF_valid
);

   logic         redirect;
   logic [31:0]  target;

   fetch_state_e state_q,      state_d;
   logic [31:0]  fetch_addr_q, fetch_addr_d;
   logic [31:0]  target_q,     target_d;
   logic [31:0]  skid_instr_q, skid_instr_d;
   logic [31:0]  skid_pc4_q,   skid_pc4_d;
   logic [31:0]  if_instr_q,   if_instr_d;
   logic [31:0]  if_pc4_q,     if_pc4_d;
   logic         if_valid_q,   if_valid_d;
   logic [31:0]  next_pc;

   pc_redirect_mux u_redirect (
      .EM_PCSrc       (EM_PCSrc),
      .EM_jump        (EM_jump),
      .EM_branch_addr (EM_branch_addr),
      .EM_jump_addr   (EM_jump_addr),
      .EM_jr_addr     (EM_jr_addr),
      .redirect       (redirect),
      .target         (target)
   );

   assign next_pc   = fetch_addr_q + 32'd4;
   assign imem.addr = fetch_addr_q;
   assign imem.req  = !rst && (state_q != FS_HOLD);
   assign IF_Instr  = if_instr_q;
   assign IF_PC4    = if_pc4_q;
   assign IF_valid  = if_valid_q;

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      target_d     = target_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      if_instr_d   = if_instr_q;
      if_pc4_d     = if_pc4_q;
      if_valid_d   = if_valid_q;

      case (state_q)
         FS_FETCH: begin
            if (redirect) begin
               if_instr_d = NOP_INSTR;
               if_valid_d = 1'b0;
               if (imem.ready) begin
                  fetch_addr_d = target;
               end else begin
                  // The old request must complete before the new address is driven.
                  target_d = target;
                  state_d  = FS_DRAIN;
               end
            end else if (imem.ready) begin
               fetch_addr_d = next_pc;
               if (stall) begin
                  skid_instr_d = imem.rdata;
                  skid_pc4_d   = next_pc;
                  state_d      = FS_HOLD;
               end else begin
                  if_instr_d = imem.rdata;
                  if_pc4_d   = next_pc;
                  if_valid_d = 1'b1;
               end
            end else if (!stall) begin
               if_instr_d = NOP_INSTR;
               if_valid_d = 1'b0;
            end
         end

         FS_HOLD: begin
            if (redirect) begin
               fetch_addr_d = target;
               if_instr_d   = NOP_INSTR;
               if_valid_d   = 1'b0;
               state_d      = FS_FETCH;
            end else if (!stall) begin
               if_instr_d = skid_instr_q;
               if_pc4_d   = skid_pc4_q;
               if_valid_d = 1'b1;
               state_d    = FS_FETCH;
            end
         end

         FS_DRAIN: begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
            if (redirect) begin
               target_d = target;
            end
            if (imem.ready) begin
               // A redirect arriving on the completing cycle is the latest one.
               fetch_addr_d = redirect ? target : target_q;
               state_d      = FS_FETCH;
            end
         end

         default: begin
            state_d = FS_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FS_FETCH;
         fetch_addr_q <= RESET_PC;
         target_q     <= 32'h0;
         skid_instr_q <= 32'h0;
         skid_pc4_q   <= 32'h0;
         if_instr_q   <= NOP_INSTR;
         if_pc4_q     <= 32'h0;
         if_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         target_q     <= target_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         if_instr_q   <= if_instr_d;
         if_pc4_q     <= if_pc4_d;
         if_valid_q   <= if_valid_d;
      end
   end

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        EM_PCSrc;
   logic [1:0]  EM_jump;
   logic [31:0] EM_branch_addr;
   logic [31:0] EM_jump_addr;
   logic [31:0] EM_jr_addr;
   logic [31:0] IF_Instr;
   logic [31:0] IF_PC4;
   logic        IF_valid;

   int errors = 0;
   int checks = 0;

   fetch_unit_if imem ();

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .EM_PCSrc       (EM_PCSrc),
      .EM_jump        (EM_jump),
      .EM_branch_addr (EM_branch_addr),
      .EM_jump_addr   (EM_jump_addr),
      .EM_jr_addr     (EM_jr_addr),
      .imem           (imem.master),
      .IF_Instr       (IF_Instr),
      .IF_PC4         (IF_PC4),
      .IF_valid       (IF_valid)
   );

   // Memory content is a tagged copy of the address, so every word is distinct and nonzero.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {8'hA5, a[23:0]};
   endfunction

   assign imem.rdata = mem(imem.addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      EM_PCSrc = 1'b0;
      EM_jump  = 2'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; imem.ready = 1'b1; clear_ctl();
      EM_branch_addr = 32'h0; EM_jump_addr = 32'h0; EM_jr_addr = 32'h0;
      step(); step();
      checks++;
      if ({IF_valid, IF_Instr, IF_PC4, imem.req, imem.addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state: actual v=%0b i=%h p=%h req=%0b a=%h required v=0 i=0 p=0 req=0 a=0",
                  IF_valid, IF_Instr, IF_PC4, imem.req, imem.addr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL first_req: actual req=%0b a=%h required req=1 a=00000000", imem.req, imem.addr);
      end
   endtask

   // Zero-wait streaming from the current address for n words.
   task automatic test_stream(input logic [31:0] start, input int n);
      logic [31:0] a;
      a = start;
      imem.ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         checks++;
         if ({IF_valid, IF_Instr, IF_PC4, imem.addr} !== {1'b1, mem(a), a + 32'd4, a + 32'd4}) begin
            errors++;
            $display("FAIL stream@%h: actual v=%0b i=%h p=%h a=%h required v=1 i=%h p=%h a=%h",
                     a, IF_valid, IF_Instr, IF_PC4, imem.addr, mem(a), a + 32'd4, a + 32'd4);
         end
         a = a + 32'd4;
      end
   endtask

   task automatic test_wait_states();
      imem.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({IF_valid, imem.req, imem.addr} !== {1'b0, 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL wait_cycle%0d: actual v=%0b req=%0b a=%h required v=0 req=1 a=00000008",
                     i, IF_valid, imem.req, imem.addr);
         end
      end
      imem.ready = 1'b1;
      step();
      checks++;
      if ({IF_valid, IF_Instr, IF_PC4, imem.addr} !== {1'b1, mem(32'h8), 32'hC, 32'hC}) begin
         errors++;
         $display("FAIL wait_accept: actual v=%0b i=%h p=%h a=%h required v=1 i=%h p=0000000c a=0000000c",
                  IF_valid, IF_Instr, IF_PC4, imem.addr, mem(32'h8));
      end
   endtask

   task automatic test_stall_hold();
      test_stream(32'hC, 1);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({IF_valid, IF_Instr, IF_PC4, imem.req, imem.addr} !== {1'b1, mem(32'hC), 32'h10, 1'b0, 32'h14}) begin
            errors++;
            $display("FAIL stall_hold%0d: actual v=%0b i=%h p=%h req=%0b a=%h required v=1 i=%h p=00000010 req=0 a=00000014",
                     i, IF_valid, IF_Instr, IF_PC4, imem.req, imem.addr, mem(32'hC));
         end
      end
      stall = 1'b0;
      step();
      checks++;
      if ({IF_valid, IF_Instr, IF_PC4, imem.req, imem.addr} !== {1'b1, mem(32'h10), 32'h14, 1'b1, 32'h14}) begin
         errors++;
         $display("FAIL stall_release: actual v=%0b i=%h p=%h req=%0b a=%h required v=1 i=%h p=00000014 req=1 a=00000014",
                  IF_valid, IF_Instr, IF_PC4, imem.req, imem.addr, mem(32'h10));
      end
      test_stream(32'h14, 3);
   endtask

   task automatic test_jr_drain();
      imem.ready = 1'b0;
      EM_jump = 2'd2; EM_jr_addr = 32'h400;
      EM_jump_addr = 32'h900; EM_branch_addr = 32'h800;
      step();
      clear_ctl();
      checks++;
      if ({IF_valid, imem.req, imem.addr} !== {1'b0, 1'b1, 32'h20}) begin
         errors++;
         $display("FAIL jr_drain0: actual v=%0b req=%0b a=%h required v=0 req=1 a=00000020",
                  IF_valid, imem.req, imem.addr);
      end
      step();
      checks++;
      if ({IF_valid, imem.addr} !== {1'b0, 32'h20}) begin
         errors++;
         $display("FAIL jr_drain1: actual v=%0b a=%h required v=0 a=00000020", IF_valid, imem.addr);
      end
      imem.ready = 1'b1;
      step();
      checks++;
      if ({IF_valid, IF_Instr, imem.addr} !== {1'b0, 32'h0, 32'h400}) begin
         errors++;
         $display("FAIL jr_complete: actual v=%0b i=%h a=%h required v=0 i=00000000 a=00000400",
                  IF_valid, IF_Instr, imem.addr);
      end
      test_stream(32'h400, 1);
   endtask

   task automatic test_hold_redirect();
      stall = 1'b1;
      step();
      checks++;
      if ({imem.req, IF_PC4} !== {1'b0, 32'h404}) begin
         errors++;
         $display("FAIL hold_enter: actual req=%0b p=%h required req=0 p=00000404", imem.req, IF_PC4);
      end
      EM_PCSrc = 1'b1; EM_branch_addr = 32'h80;
      step();
      clear_ctl();
      checks++;
      if ({IF_valid, IF_Instr, imem.req, imem.addr} !== {1'b0, 32'h0, 1'b1, 32'h80}) begin
         errors++;
         $display("FAIL hold_flush: actual v=%0b i=%h req=%0b a=%h required v=0 i=00000000 req=1 a=00000080",
                  IF_valid, IF_Instr, imem.req, imem.addr);
      end
      stall = 1'b0;
      test_stream(32'h80, 1);
   endtask

   task automatic test_priority();
      EM_PCSrc = 1'b1; EM_branch_addr = 32'h40;
      EM_jump = 2'd1;  EM_jump_addr = 32'h100;
      imem.ready = 1'b1;
      step();
      clear_ctl();
      checks++;
      if ({IF_valid, imem.addr} !== {1'b0, 32'h100}) begin
         errors++;
         $display("FAIL branch_vs_j: actual v=%0b a=%h required v=0 a=00000100", IF_valid, imem.addr);
      end
      test_stream(32'h100, 1);
      // jump code 3 is not a redirect
      EM_jump = 2'd3; EM_jr_addr = 32'h700; EM_jump_addr = 32'h600;
      test_stream(32'h104, 1);
      clear_ctl();
   endtask

   task automatic test_rst_in_drain();
      imem.ready = 1'b0;
      EM_jump = 2'd1; EM_jump_addr = 32'h200;
      step();
      clear_ctl();
      rst = 1'b1;
      step();
      checks++;
      if ({IF_valid, IF_Instr, imem.addr} !== {1'b0, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL rst_drain: actual v=%0b i=%h a=%h required v=0 i=00000000 a=00000000",
                  IF_valid, IF_Instr, imem.addr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (imem.req !== 1'b1) begin
         errors++;
         $display("FAIL rst_drain_req: actual req=%0b required req=1", imem.req);
      end
      test_stream(32'h0, 1);
   endtask

   task automatic test_wrap();
      EM_jump = 2'd1; EM_jump_addr = 32'hFFFF_FFFC;
      imem.ready = 1'b1;
      step();
      clear_ctl();
      checks++;
      if (imem.addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_target: actual a=%h required a=fffffffc", imem.addr);
      end
      test_stream(32'hFFFF_FFFC, 2);
   endtask

   initial begin
      test_reset();
      test_stream(32'h0, 2);
      test_wait_states();
      test_stall_hold();
      test_jr_drain();
      test_hold_redirect();
      test_priority();
      test_rst_in_drain();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_unit

`default_nettype wire
